// File: rtl/weight_vec_gen_if.sv
// weight_vec_gen_if: request/response stream bundle for the weight-vector generator.
// A request carries a Hamming weight. Each response beat carries one N-bit vector
// with that many ones, its ordinal, a last flag and an error flag.
interface weight_vec_gen_if #(
  parameter int N  = 5,
  parameter int WW = 3,
  parameter int IW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic [WW-1:0] req_weight;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_vec;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          out_err;
  logic          chk_err;

  modport master (
    output req_valid, req_weight, out_ready,
    input  req_ready, out_valid, out_vec, out_index, out_last, out_err, chk_err
  );

  modport slave (
    input  req_valid, req_weight, out_ready,
    output req_ready, out_valid, out_vec, out_index, out_last, out_err, chk_err
  );
endinterface

// File: rtl/weight_vec_gen.sv
// weight_vec_gen: enumerates every N-bit vector of a requested Hamming weight in
// ascending order, one vector per accepted beat, using Gosper's successor.
// Optional self-check: define WEIGHT_VEC_GEN_POPCHK_EN to build a popcount and
// ordering checker that drives the sticky chk_err flag. Without it, chk_err is 0.
module weight_vec_gen #(
  parameter int N  = 5,
  parameter int WW = 3,
  parameter int IW = 8
) (
  input logic             clk,
  input logic             rst,
  weight_vec_gen_if.slave bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [N-1:0]  ONE_V   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] ONE_I   = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] N_W     = WW'(N);

  // Vector with the low k bits set; this is the first member of the enumeration.
  function automatic logic [N-1:0] low_mask(input logic [WW-1:0] k);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i < int'(k));
    return m;
  endfunction

  // Vector with the top k bits set; this is the final member of the enumeration.
  function automatic logic [N-1:0] top_mask(input logic [WW-1:0] k);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i >= N - int'(k));
    return m;
  endfunction

  // Count trailing zeros. An all-zero vector yields N, which the callers never use.
  function automatic logic [4:0] ctz(input logic [N-1:0] v);
    logic [4:0] r;
    r = 5'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

  state_t        state_r, state_s;
  logic [WW-1:0] k_r, k_s;
  logic          req_ready_r, req_ready_s;
  logic          out_valid_r, out_valid_s;
  logic [N-1:0]  out_vec_r, out_vec_s;
  logic [IW-1:0] out_index_r, out_index_s;
  logic          out_last_r, out_last_s;
  logic          out_err_r, out_err_s;
  logic          chk_err_s;
  logic          hs_s;

  // Gosper successor of the current vector, computed in N-bit arithmetic.
  logic [N-1:0]  t_s, t1_s, low_s, succ_s;
  logic [4:0]    shamt_s;
  assign t_s     = out_vec_r | (out_vec_r - ONE_V);
  assign t1_s    = t_s + ONE_V;
  assign low_s   = (~t_s & t1_s) - ONE_V;
  assign shamt_s = ctz(out_vec_r) + 5'd1;
  assign succ_s  = t1_s | (low_s >> shamt_s);

  // A beat leaves the block only while enumerating.
  assign hs_s = (state_r == ST_RUN) && out_valid_r && bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_s     = state_r;
    k_s         = k_r;
    req_ready_s = req_ready_r;
    out_valid_s = out_valid_r;
    out_vec_s   = out_vec_r;
    out_index_s = out_index_r;
    out_last_s  = out_last_r;
    out_err_s   = out_err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_r) begin
          state_s     = ST_RUN;
          k_s         = bus.req_weight;
          req_ready_s = 1'b0;
          out_valid_s = 1'b1;
          out_index_s = '0;
          if (bus.req_weight > N_W) begin
            out_vec_s  = '0;
            out_err_s  = 1'b1;
            out_last_s = 1'b1;
          end else begin
            out_vec_s  = low_mask(bus.req_weight);
            out_err_s  = 1'b0;
            out_last_s = (low_mask(bus.req_weight) == top_mask(bus.req_weight));
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ST_RUN: begin
        if (hs_s) begin
          if (out_last_r) begin
            state_s     = ST_IDLE;
            out_valid_s = 1'b0;
            req_ready_s = 1'b1;
          end else begin
            out_vec_s   = succ_s;
            out_index_s = out_index_r + ONE_I;
            out_last_s  = (succ_s == top_mask(k_r));
          end
        end else begin
          out_valid_s = out_valid_r;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        req_ready_s = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Output and weight registers; reset abandons any enumeration in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r         <= '0;
      req_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
      out_vec_r   <= '0;
      out_index_r <= '0;
      out_last_r  <= 1'b0;
      out_err_r   <= 1'b0;
    end else begin
      k_r         <= k_s;
      req_ready_r <= req_ready_s;
      out_valid_r <= out_valid_s;
      out_vec_r   <= out_vec_s;
      out_index_r <= out_index_s;
      out_last_r  <= out_last_s;
      out_err_r   <= out_err_s;
    end
  end

`ifdef WEIGHT_VEC_GEN_POPCHK_EN
  // Number of ones in a vector; fits WW bits because 2^WW > N.
  function automatic logic [WW-1:0] popcount(input logic [N-1:0] v);
    logic [WW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + {{(WW-1){1'b0}}, v[i]};
    return c;
  endfunction

  logic         chk_err_r;
  logic [N-1:0] prev_vec_r;
  logic         have_prev_r;

  // Sticky check: each emitted vector has weight k and exceeds its predecessor.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_r   <= 1'b0;
      prev_vec_r  <= '0;
      have_prev_r <= 1'b0;
    end else if (hs_s && !out_err_r) begin
      if ((popcount(out_vec_r) != k_r) || (have_prev_r && (out_vec_r <= prev_vec_r))) begin
        chk_err_r <= 1'b1;
      end
      prev_vec_r  <= out_vec_r;
      have_prev_r <= !out_last_r;
    end else begin
      chk_err_r <= chk_err_r;
    end
  end

  assign chk_err_s = chk_err_r;
`else
  assign chk_err_s = 1'b0;
`endif

  assign bus.req_ready = req_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_vec   = out_vec_r;
  assign bus.out_index = out_index_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_err   = out_err_r;
  assign bus.chk_err   = chk_err_s;

endmodule

// File: tb/tb_weight_vec_gen.sv
// tb_weight_vec_gen: directed bench for weight_vec_gen with N=5, WW=3, IW=8.
module tb_weight_vec_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [7:0] exp_q[$];

  weight_vec_gen_if #(.N(5), .WW(3), .IW(8)) bus ();

  weight_vec_gen #(.N(5), .WW(3), .IW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid_low"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  // Issue one request and confirm the one-cycle acceptance latency.
  task automatic request(input logic [2:0] k);
    int b;
    b = 0;
    while (!bus.req_ready && b < 20) begin
      step();
      b++;
    end
    check("req_ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_weight = k;
    bus.req_valid  = 1'b1;
    check("valid_before_accept", 32'(bus.out_valid), 32'd0);
    step();
    bus.req_valid = 1'b0;
    check("valid_after_accept", 32'(bus.out_valid), 32'd1);
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
  endtask

  // Accept every beat with out_ready=1 and compare against exp_q.
  task automatic drain(input string tag);
    int b;
    bus.out_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      b = 0;
      while (!bus.out_valid && b < 20) begin
        step();
        b++;
      end
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_vec"},   32'(bus.out_vec),   32'(exp_q[i]));
      check({tag, "_index"}, 32'(bus.out_index), 32'(i));
      check({tag, "_last"},  32'(bus.out_last),  32'(i == exp_q.size() - 1));
      check({tag, "_err"},   32'(bus.out_err),   32'd0);
      step();
    end
    check_idle(tag);
  endtask

  initial begin
    int got;
    int cyc;
    int cnt;
    int b;
    int total;
    logic [3:0] pat;
    int ctab[6];

    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_weight = 3'd0;
    bus.out_ready  = 1'b0;
    #1;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_out_vec",   32'(bus.out_vec),   32'd0);
    check("rst_out_index", 32'(bus.out_index), 32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);
    check("rst_chk_err",   32'(bus.chk_err),   32'd0);
    rst = 1'b0;
    step();

    // Weight 2: ten vectors, last on 18.
    bus.out_ready = 1'b1;
    request(3'd2);
    exp_q = '{8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11, 8'h12, 8'h14, 8'h18};
    drain("k2");

    // Weight 0 and weight N: a single vector each.
    request(3'd0);
    exp_q = '{8'h00};
    drain("k0");
    request(3'd5);
    exp_q = '{8'h1F};
    drain("k5");

    // Weight above N: one error beat.
    request(3'd6);
    check("k6_vec",   32'(bus.out_vec),   32'd0);
    check("k6_err",   32'(bus.out_err),   32'd1);
    check("k6_last",  32'(bus.out_last),  32'd1);
    check("k6_index", 32'(bus.out_index), 32'd0);
    step();
    check_idle("k6");

    // Weight 3 under back-pressure, out_ready pattern 1,0,0,1.
    pat = 4'b1001;
    request(3'd3);
    exp_q = '{8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19, 8'h1A, 8'h1C};
    got = 0;
    cyc = 0;
    while (got < 10 && cyc < 80) begin
      bus.out_ready = pat[cyc % 4];
      if (bus.out_valid) begin
        check("k3s_vec",   32'(bus.out_vec),   32'(exp_q[got]));
        check("k3s_index", 32'(bus.out_index), 32'(got));
        check("k3s_last",  32'(bus.out_last),  32'(got == 9));
        if (bus.out_ready) got++;
      end
      step();
      cyc++;
    end
    check("k3s_count", 32'(got), 32'd10);
    check_idle("k3s");

    // Reset in the middle of a weight-3 enumeration.
    bus.out_ready = 1'b1;
    request(3'd3);
    exp_q = '{8'h07, 8'h0B, 8'h0D, 8'h0E};
    for (int i = 0; i < 4; i++) begin
      check("midrst_vec", 32'(bus.out_vec), 32'(exp_q[i]));
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_vec0",  32'(bus.out_vec),   32'd0);
    check("midrst_index", 32'(bus.out_index), 32'd0);
    check("midrst_last",  32'(bus.out_last),  32'd0);
    check("midrst_err",   32'(bus.out_err),   32'd0);
    request(3'd1);
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    drain("k1");

    // Every weight back to back: 1+5+10+10+5+1 = 32 beats, no check error.
    ctab = '{1, 5, 10, 10, 5, 1};
    total = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      request(3'(k));
      cnt = 0;
      b = 0;
      while (bus.out_valid && b < 40) begin
        cnt++;
        step();
        b++;
      end
      check("sweep_count", 32'(cnt), 32'(ctab[k]));
      total += cnt;
    end
    check("sweep_total", 32'(total), 32'd32);
    check("sweep_chk_err", 32'(bus.chk_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_vec_gen.md
Name: weight_vec_gen

Overview:
- Inverse of the team's 5-input ones-count (rd53-class) logic: takes a requested Hamming weight and enumerates every N-bit vector with exactly that many ones.
- Vectors leave in ascending numeric order, one per cycle, over a valid/ready stream.
- Used as a stimulus source for the popcount/symmetric-function benchmarks in the power-aware synthesis training flow. It also serves as a hardware reference for counter equivalence checks.

Parameters:
- N, 5, vector width (2..16).
- WW, 3, weight field width; must satisfy 2^WW > N.
- IW, 8, width of out_index. It must hold C(N, floor(N/2)) - 1; that value is 9 for N=5.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  enumeration request valid.
- req_ready  out  1  block can accept a request (IDLE only).
- req_weight  in  WW  requested number of ones.
- out_valid  out  1  out_vec/out_index/out_last/out_err valid.
- out_ready  in  1  downstream accepts output.
- out_vec  out  N  current vector.
- out_index  out  IW  ordinal of out_vec within the enumeration, starting at 0.
- out_last  out  1  final vector of the enumeration.
- out_err  out  1  request weight exceeded N.
- chk_err  out  1  sticky self-check failure (see Optional Feature).

Behaviour:
- Reset (sync, active-high, clk edge), including mid-enumeration:
  - state=IDLE, req_ready=1, out_valid=0.
  - out_vec=0, out_index=0, out_last=0, out_err=0, chk_err=0.
  - Any enumeration in progress is abandoned with no further outputs.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready the weight k is latched and the state moves to RUN. The output regs load at the same edge, so out_valid=1 on the next cycle (latency 1).
  - RUN: req_ready=0. The output regs hold while out_valid&!out_ready.
  - On out_valid&out_ready with out_last=0, the next vector loads at that edge, giving a throughput of 1/cycle.
  - On out_valid&out_ready with out_last=1, out_valid drops to 0 and the state returns to IDLE. req_ready=1 the following cycle (one bubble); there is no request overlap.
- First vector: the low k bits set, value (1<<k)-1, with out_index=0.
- Next vector uses Gosper's successor with N-bit-masked arithmetic:
  - t = v | (v-1)
  - next = (t+1) | (((~t & (t+1)) - 1) >> (ctz(v)+1))
  - ctz is computed combinationally over N bits.
  - out_index increments by 1 per handshake.
- out_last=1 when v equals the top k bits set, value ((1<<k)-1) << (N-k).
- Enumeration length: C(N,k) vectors. For N=5, k=0..5 gives 1,5,10,10,5,1.
- k=0: a single vector 0 with out_last=1. The Gosper path is not used, because ctz(0) is undefined.
- k=N: a single vector of all ones with out_last=1.
- k>N: a single output with out_vec=0, out_err=1, out_last=1, out_index=0. out_err is 0 for every valid weight.
- Output signals are registered with no combinational path from inputs to outputs. out_ready is sampled only in RUN.

Optional Feature:
- Macro: WEIGHT_VEC_GEN_POPCHK_EN.
- Defined:
  - An internal combinational popcount of out_vec is compared with the latched k on every handshake with out_err=0.
  - Any mismatch, or out_vec not strictly greater than the previous vector within one enumeration, sets chk_err=1.
  - chk_err stays set until rst.
- Undefined: chk_err is tied to 0 and no checker logic is synthesised. The port list is identical in both builds.

Test Plan:
1. rst high for 2 cycles, then request k=2 with out_ready=1 continuously:
   - out_valid rises 1 cycle after acceptance.
   - Vectors are 03,05,06,09,0A,0C,11,12,14,18 (hex) with index 0..9.
   - out_last=1 only on 18; req_ready returns 1 cycle later.
2. Request k=0, then k=5:
   - k=0 gives a single 00 with out_last=1.
   - k=5 gives a single 1F with out_last=1.
   - out_err=0 for both.
3. Request k=6 (N=5): a single output with out_vec=00, out_err=1, out_last=1, then the state returns to IDLE.
4. Request k=3 with out_ready toggling 1,0,0,1,…:
   - Outputs are stable while stalled.
   - The full sequence 07,0B,0D,0E,13,15,16,19,1A,1C is delivered with no drop or duplicate.
5. Request k=3, then assert rst after the 4th handshake:
   - The next cycle shows out_valid=0, req_ready=1, and all outputs 0.
   - A new k=1 request yields 01,02,04,08,10.
6. Build with WEIGHT_VEC_GEN_POPCHK_EN and run k=0..5 back-to-back:
   - chk_err stays 0 throughout.
   - Total handshakes are 32, which equals 2^5.
